// File: rtl/stage_fifo_pkg.sv
// -----------------------------------------------------------------------------
// stage_fifo_pkg
//   Shared defaults and helpers for the stage_fifo elastic buffer.
//
//   STAGE_FIFO_WIDTH : default payload width in bits.
//   STAGE_FIFO_DEPTH : default number of entries (power of two, 2..16).
//   PTR_MAX_W        : pointer width large enough for the deepest legal FIFO.
//   ptr_next()       : wrap-around increment of a FIFO pointer.
// -----------------------------------------------------------------------------
package stage_fifo_pkg;

    localparam int STAGE_FIFO_WIDTH = 8;
    localparam int STAGE_FIFO_DEPTH = 4;

    // Largest legal DEPTH is 16, so four pointer bits always suffice.
    localparam int PTR_MAX_W = 4;

    // Advance a pointer by one, returning to zero after depth-1.
    // The pointer is carried at PTR_MAX_W bits. Callers zero-extend their
    // narrower pointer on the way in and truncate the result on the way out.
    // Because depth is a power of two, truncation alone would also wrap.
    // The explicit compare keeps the function correct for any depth.
    function automatic logic [PTR_MAX_W-1:0] ptr_next(
        input logic [PTR_MAX_W-1:0] ptr,
        input int                   depth
    );
        if (32'(ptr) == depth - 1) begin
            return '0;
        end
        return ptr + PTR_MAX_W'(1);
    endfunction

endpackage : stage_fifo_pkg

// File: rtl/stage_fifo.sv
// -----------------------------------------------------------------------------
// stage_fifo
//   Single-clock valid/ready FIFO used as an elastic stage between a producer
//   and a consumer. Storage is a plain register array. The output is always
//   the entry at the read pointer, with no bypass path. A push into an empty
//   FIFO therefore reaches the output one cycle later.
//
// Parameters
//   WIDTH     : payload bits per entry.
//   DEPTH     : number of entries (power of two, 2..16).
//
// Ports
//   clk       : in   single clock, all state on the rising edge.
//   rst       : in   synchronous active-high reset.
//   in_valid  : in   producer offers in_data.
//   in_ready  : out  FIFO can accept (not full); depends on state only.
//   in_data   : in   producer payload.
//   out_valid : out  out_data holds the oldest entry (not empty).
//   out_ready : in   consumer takes out_data this cycle.
//   out_data  : out  oldest stored entry.
//   count     : out  number of stored entries, 0..DEPTH.
//   overflow  : out  sticky: in_valid seen while full; cleared by reset only.
// -----------------------------------------------------------------------------
module stage_fifo
    import stage_fifo_pkg::*;
#(
    parameter int WIDTH = STAGE_FIFO_WIDTH,
    parameter int DEPTH = STAGE_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);   // pointer width
    localparam int CW = $clog2(DEPTH) + 1; // count width, holds 0..DEPTH

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    // ---------------------------------------------------------------------
    // Combinational status and handshakes
    // ---------------------------------------------------------------------
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_wr_nxt;
    logic [AW-1:0] w_rd_nxt;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // in_ready looks only at stored state and never at out_ready. A full
    // FIFO therefore turns a push away even when a pop frees a slot in the
    // same cycle. This keeps the ready path free of any consumer-side
    // combinational loop.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;

    assign w_push = in_valid  && !w_full;
    assign w_pop  = out_ready && !w_empty;

    assign w_wr_nxt = AW'(ptr_next(PTR_MAX_W'(r_wr_ptr), DEPTH));
    assign w_rd_nxt = AW'(ptr_next(PTR_MAX_W'(r_rd_ptr), DEPTH));

    assign out_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;

    // ---------------------------------------------------------------------
    // Storage: not reset. Contents are don't-care until written.
    // Writes are suppressed during reset so a discarded push leaves no trace.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // ---------------------------------------------------------------------
    // Pointers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Occupancy. A simultaneous push and pop leaves count unchanged.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Sticky overflow. It flags the attempt only. The rejected data never
    // touches storage or pointers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

endmodule : stage_fifo

// File: doc/stage_fifo.md
STAGE_FIFO -- requirements
Module: stage_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload bits per entry.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer offers in_data this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  payload from producer.
REQ-008 SHALL have port out_valid  output  1  out_data holds the oldest stored entry.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  oldest stored entry.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 SHALL have port overflow  output  1  sticky flag: push attempted while full.

Function
REQ-013 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-014 SHALL drive in_ready = (count != DEPTH), combinationally from registered state only, with no dependence on out_ready.
REQ-015 SHALL drive out_valid = (count != 0), combinationally from registered state only.
REQ-016 SHALL drive out_data from the storage entry at rd_ptr, with no bypass from in_data; a push into an empty FIFO becomes visible on the output one cycle later.
REQ-017 SHALL write in_data into the entry at wr_ptr on push, then advance wr_ptr by 1 modulo DEPTH.
REQ-018 SHALL advance rd_ptr by 1 modulo DEPTH on pop; the wrap from DEPTH-1 to 0 requires no extra cycle.
REQ-019 SHALL update count as follows: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-020 SHALL allow push and pop in the same cycle whenever 0 < count < DEPTH.
REQ-021 SHALL reject input when full (in_ready=0), even if pop occurs in the same cycle; entry is accepted the following cycle.
REQ-022 SHALL set overflow when in_valid=1 and count=DEPTH; it holds until reset; storage and pointers are unaffected.
REQ-023 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL use every declared signal; no variable is left unread or undriven.

Reset
REQ-025 SHALL clear wr_ptr, rd_ptr, count and overflow to 0 when rst=1 at a clock edge; out_valid=0 and in_ready=1 in the next cycle.
REQ-026 SHALL discard all stored entries and ignore push/pop when rst is asserted mid-operation.
REQ-027 SHALL NOT reset storage contents; out_data is don't-care while out_valid=0.

Structure
REQ-028 SHALL take the defaults STAGE_FIFO_WIDTH=8 and STAGE_FIFO_DEPTH=4, and the function ptr_next(ptr) for wrap increment, from package stage_fifo_pkg.
REQ-029 SHALL be a single module with no sub-modules; storage is an unpacked array of DEPTH x WIDTH registers.

Verification
REQ-030 SHALL be verified by a fill test: after reset, push 8'h11,8'h22,8'h33,8'h44 with out_ready=0 -> count=4, in_ready=0, out_data=8'h11.
REQ-031 SHALL be verified by a drain test: from the full state, out_ready=1 for 4 cycles -> out_data is 11,22,33,44 in order, then out_valid=0 and count=0.
REQ-032 SHALL be verified by a wrap test: keep in_valid=out_ready=1 for 10 cycles with an incrementing pattern starting at 8'h00 -> outputs match in order, count stays 1 after the first push, pointers wrap twice.
REQ-033 SHALL be verified by a full-plus-pop test: at count=4 drive in_valid=1 and out_ready=1 -> pop occurs, push is rejected, count=3, overflow=1.
REQ-034 SHALL be verified by a mid-operation reset: assert rst for one cycle at count=3 -> count=0, out_valid=0, in_ready=1, overflow=0; the next push of 8'hA5 appears at out_data one cycle later.
REQ-035 SHALL be verified by an empty-push test: push 8'h5A at count=0 with out_ready=1 -> out_valid=0 in that cycle, out_valid=1 with out_data=8'h5A the next cycle.
